// File: rtl/ctrl_seq_if.sv
// Bus bundle between control_sequencer and its environment: instruction fetch,
// data memory read/write port and ALU start/done handshake.
interface ctrl_seq_if #(
    parameter int DW  = 8,
    parameter int OPW = 6,
    parameter int AW  = 8
);
    localparam int CMD_W = OPW + 2 * (DW + 1);

    logic             cmd_req;
    logic [AW-1:0]    cmd_addr;
    logic             cmd_valid;
    logic [CMD_W-1:0] cmd_data;

    logic             mem_rd_req;
    logic [DW-1:0]    mem_rd_addr;
    logic             mem_rd_valid;
    logic [DW-1:0]    mem_rd_data;

    logic             mem_wr_en;
    logic [DW-1:0]    mem_wr_addr;
    logic [DW-1:0]    mem_wr_data;

    logic             alu_start;
    logic [3:0]       alu_op;
    logic [DW-1:0]    alu_a;
    logic [DW-1:0]    alu_b;
    logic             alu_done;
    logic [DW-1:0]    alu_result;

    modport master (
        output cmd_req, cmd_addr,
        input  cmd_valid, cmd_data,
        output mem_rd_req, mem_rd_addr,
        input  mem_rd_valid, mem_rd_data,
        output mem_wr_en, mem_wr_addr, mem_wr_data,
        output alu_start, alu_op, alu_a, alu_b,
        input  alu_done, alu_result
    );

    modport slave (
        input  cmd_req, cmd_addr,
        output cmd_valid, cmd_data,
        input  mem_rd_req, mem_rd_addr,
        output mem_rd_valid, mem_rd_data,
        input  mem_wr_en, mem_wr_addr, mem_wr_data,
        input  alu_start, alu_op, alu_a, alu_b,
        output alu_done, alu_result
    );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer: fetch, operand resolve, ALU dispatch, write-back, jumps.
// Optional macro CTRL_SEQ_HALT_EN: opcode 8 halts the sequencer and adds the halted output.
//
// state   | meaning
// FETCH   | cmd_req held, latch command on cmd_valid
// DEC     | split fields, load immediates, pick operand path
// RD1     | read operand 1 from memory
// RD2     | read operand 2 from memory (add/sub only)
// EXEC    | one-cycle alu_start
// WAIT    | wait for alu_done, update acc/flags
// WB      | mov write strobe
// RET     | retire pulse, advance or redirect ip
// HALT    | parked until reset (macro build only)
module control_sequencer #(
    parameter int DW  = 8,
    parameter int OPW = 6,
    parameter int AW  = 8
) (
    input  logic          clock,
    input  logic          reset,
    ctrl_seq_if.master    bus,
    output logic [DW-1:0] acc,
    output logic [AW-1:0] ip,
    output logic          flag_z,
    output logic          flag_lt,
    output logic          illegal,
    output logic          retire
`ifdef CTRL_SEQ_HALT_EN
    ,
    output logic          halted
`endif
);
    localparam int CMD_W = OPW + 2 * (DW + 1);

    localparam logic [OPW-1:0] OP_NOP  = OPW'(0);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(1);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(2);
    localparam logic [OPW-1:0] OP_INV  = OPW'(3);
    localparam logic [OPW-1:0] OP_MOV  = OPW'(4);
    localparam logic [OPW-1:0] OP_JFE  = OPW'(5);
    localparam logic [OPW-1:0] OP_JFL  = OPW'(6);
    localparam logic [OPW-1:0] OP_JFG  = OPW'(7);
`ifdef CTRL_SEQ_HALT_EN
    localparam logic [OPW-1:0] OP_HALT = OPW'(8);
    localparam logic [OPW-1:0] OP_LAST = OP_HALT;
`else
    localparam logic [OPW-1:0] OP_LAST = OP_JFG;
`endif

    typedef enum logic [3:0] {
        S_FETCH, S_DEC, S_RD1, S_RD2, S_EXEC, S_WAIT, S_WB, S_RET, S_HALT
    } state_t;

    state_t           state, state_n;
    logic [CMD_W-1:0] cmd_q;
    logic [DW-1:0]    op1, op2;

    logic [OPW-1:0] opc;
    logic           f1, f2;
    logic [DW-1:0]  v1, v2;
    assign opc = cmd_q[CMD_W-1 -: OPW];
    assign f1  = cmd_q[2*DW+1];
    assign v1  = cmd_q[2*DW -: DW];
    assign f2  = cmd_q[DW];
    assign v2  = cmd_q[DW-1:0];

    logic is_nop, is_add, is_sub, is_inv, is_mov, is_jfe, is_jfl, is_jfg, is_halt;
    logic legal, uses_alu, uses_rd2, taken;
    logic [AW-1:0] target;

    assign is_nop   = (opc == OP_NOP);
    assign is_add   = (opc == OP_ADD);
    assign is_sub   = (opc == OP_SUB);
    assign is_inv   = (opc == OP_INV);
    assign is_mov   = (opc == OP_MOV);
    assign is_jfe   = (opc == OP_JFE);
    assign is_jfl   = (opc == OP_JFL);
    assign is_jfg   = (opc == OP_JFG);
`ifdef CTRL_SEQ_HALT_EN
    assign is_halt  = (opc == OP_HALT);
`else
    assign is_halt  = 1'b0;
`endif
    assign legal    = (opc <= OP_LAST);
    assign uses_alu = is_add | is_sub | is_inv;
    assign uses_rd2 = (is_add | is_sub) & f2;
    assign target   = AW'(op1);
    assign taken    = (is_jfe & flag_z) | (is_jfl & flag_lt) | (is_jfg & ~flag_z & ~flag_lt);

    // Where to go once operand 1 is resolved: ALU, write-back, or straight to retire for jumps.
    state_t after_op1;
    always_comb begin
        after_op1 = S_RET;
        if (uses_rd2)
            after_op1 = S_RD2;
        else if (uses_alu)
            after_op1 = S_EXEC;
        else if (is_mov)
            after_op1 = S_WB;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= S_FETCH;
        else
            state <= state_n;
    end

    always_comb begin
        state_n          = state;
        bus.cmd_req      = 1'b0;
        bus.cmd_addr     = '0;
        bus.mem_rd_req   = 1'b0;
        bus.mem_rd_addr  = '0;
        bus.mem_wr_en    = 1'b0;
        bus.mem_wr_addr  = '0;
        bus.mem_wr_data  = '0;
        bus.alu_start    = 1'b0;
        bus.alu_op       = '0;
        bus.alu_a        = '0;
        bus.alu_b        = '0;
        illegal          = 1'b0;
        retire           = 1'b0;
        case (state)
            S_FETCH: begin
                bus.cmd_req  = ~reset;
                bus.cmd_addr = ip;
                if (bus.cmd_valid)
                    state_n = S_DEC;
            end
            S_DEC: begin
                illegal = ~legal;
                if (!legal || is_nop || is_halt)
                    state_n = S_RET;
                else if (f1)
                    state_n = S_RD1;
                else
                    state_n = after_op1;
            end
            S_RD1: begin
                bus.mem_rd_req  = 1'b1;
                bus.mem_rd_addr = v1;
                if (bus.mem_rd_valid)
                    state_n = after_op1;
            end
            S_RD2: begin
                bus.mem_rd_req  = 1'b1;
                bus.mem_rd_addr = v2;
                if (bus.mem_rd_valid)
                    state_n = S_EXEC;
            end
            S_EXEC: begin
                bus.alu_start = 1'b1;
                bus.alu_op    = opc[3:0];
                bus.alu_a     = op1;
                bus.alu_b     = op2;
                state_n       = S_WAIT;
            end
            S_WAIT: begin
                bus.alu_op = opc[3:0];
                bus.alu_a  = op1;
                bus.alu_b  = op2;
                if (bus.alu_done)
                    state_n = S_RET;
            end
            S_WB: begin
                bus.mem_wr_en   = 1'b1;
                bus.mem_wr_addr = v2;
                bus.mem_wr_data = op1;
                state_n         = S_RET;
            end
            S_RET: begin
                retire  = 1'b1;
                state_n = is_halt ? S_HALT : S_FETCH;
            end
            S_HALT:  state_n = S_HALT;
            default: state_n = S_FETCH;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmd_q   <= '0;
            op1     <= '0;
            op2     <= '0;
            acc     <= '0;
            ip      <= '0;
            flag_z  <= 1'b0;
            flag_lt <= 1'b0;
        end else begin
            case (state)
                S_FETCH: if (bus.cmd_valid) cmd_q <= bus.cmd_data;
                S_DEC: begin
                    op1 <= v1;
                    op2 <= v2;
                end
                S_RD1: if (bus.mem_rd_valid) op1 <= bus.mem_rd_data;
                S_RD2: if (bus.mem_rd_valid) op2 <= bus.mem_rd_data;
                S_WAIT: begin
                    if (bus.alu_done) begin
                        acc <= bus.alu_result;
                        // Flags reflect only the most recent sub; lt uses the raw operands.
                        if (is_sub) begin
                            flag_z  <= (bus.alu_result == '0);
                            flag_lt <= (op1 < op2);
                        end
                    end
                end
                S_RET: begin
                    if (!is_halt)
                        ip <= taken ? target : ip + AW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef CTRL_SEQ_HALT_EN
    assign halted = (state == S_HALT);
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed program, environment responders,
// expected-event queue drained by an independent monitor.
module tb_control_sequencer;
    localparam int DW = 8, OPW = 6, AW = 8;
    localparam int CMD_W = OPW + 2 * (DW + 1);

    localparam int EV_ALU = 1, EV_RD = 2, EV_WR = 3, EV_RET = 4, EV_ILL = 5;

    typedef struct {
        int kind;
        int f0;
        int f1;
        int f2;
    } ev_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ctrl_seq_if #(.DW(DW), .OPW(OPW), .AW(AW)) bus ();

    logic [DW-1:0] acc;
    logic [AW-1:0] ip;
    logic          flag_z, flag_lt, illegal, retire;
`ifdef CTRL_SEQ_HALT_EN
    logic          halted;
`endif

    control_sequencer #(.DW(DW), .OPW(OPW), .AW(AW)) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .acc     (acc),
        .ip      (ip),
        .flag_z  (flag_z),
        .flag_lt (flag_lt),
        .illegal (illegal),
        .retire  (retire)
`ifdef CTRL_SEQ_HALT_EN
        ,
        .halted  (halted)
`endif
    );

    logic [CMD_W-1:0] prog [256];
    logic [DW-1:0]    dmem [256];
    ev_t              exp_q [$];
    int compared = 0;
    int mismatched = 0;
    int served = 0;
    int serve_limit = 0;
    logic alu_stall = 1'b0;
    logic ip_pend = 1'b0;
    int ip_exp = 0;

    function automatic logic [CMD_W-1:0] enc(int op, int f1, int v1, int f2, int v2);
        logic [CMD_W-1:0] w;
        w = {OPW'(op), 1'(f1), DW'(v1), 1'(f2), DW'(v2)};
        return w;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(int kind, int a, int b, int c);
        ev_t e;
        e.kind = kind; e.f0 = a; e.f1 = b; e.f2 = c;
        exp_q.push_back(e);
    endtask

    task automatic e_ret(int acc_v, int z, int lt, int ipn);
        push(EV_RET, acc_v, z * 2 + lt, ipn);
    endtask

    task automatic take(int kind, int a, int b, int c);
        ev_t e;
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_event: got kind %0d expected none", kind);
            return;
        end
        e = exp_q.pop_front();
        check("event_kind", kind, e.kind);
        check("event_f0", a, e.f0);
        check("event_f1", b, e.f1);
        if (kind == EV_RET) begin
            ip_exp  = e.f2;
            ip_pend = 1'b1;
        end else begin
            check("event_f2", c, e.f2);
        end
    endtask

    // Monitor: every DUT-initiated event is matched against the head of the queue.
    initial begin
        logic          prev_rd;
        logic [DW-1:0] prev_addr;
        prev_rd = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_rd = 1'b0;
                ip_pend = 1'b0;
                continue;
            end
            if (ip_pend) begin
                check("ip_next", ip, ip_exp);
                ip_pend = 1'b0;
            end
            if (bus.alu_start)
                take(EV_ALU, bus.alu_op, bus.alu_a, bus.alu_b);
            if (bus.mem_rd_req && (!prev_rd || bus.mem_rd_addr != prev_addr))
                take(EV_RD, bus.mem_rd_addr, 0, 0);
            prev_rd = bus.mem_rd_req;
            prev_addr = bus.mem_rd_addr;
            if (bus.mem_wr_en)
                take(EV_WR, bus.mem_wr_addr, bus.mem_wr_data, 0);
            if (illegal)
                take(EV_ILL, 0, 0, 0);
            if (retire)
                take(EV_RET, acc, {flag_z, flag_lt}, 0);
        end
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_data = '0;
        forever begin
            @(negedge clock);
            if (bus.cmd_req && !bus.cmd_valid && served < serve_limit) begin
                bus.cmd_data = prog[bus.cmd_addr];
                bus.cmd_valid = 1'b1;
                served++;
            end else begin
                bus.cmd_valid = 1'b0;
            end
        end
    end

    initial begin
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data = '0;
        forever begin
            @(negedge clock);
            if (bus.mem_rd_req && !bus.mem_rd_valid) begin
                bus.mem_rd_data = dmem[bus.mem_rd_addr];
                bus.mem_rd_valid = 1'b1;
            end else begin
                bus.mem_rd_valid = 1'b0;
            end
        end
    end

    // ALU stand-in: answers two cycles after each start unless stalled.
    initial begin
        logic [DW-1:0] r;
        bus.alu_done = 1'b0;
        bus.alu_result = '0;
        forever begin
            @(negedge clock);
            bus.alu_done = 1'b0;
            if (bus.alu_start && !alu_stall && !reset) begin
                case (bus.alu_op)
                    4'd1:    r = bus.alu_a + bus.alu_b;
                    4'd2:    r = bus.alu_a - bus.alu_b;
                    4'd3:    r = ~bus.alu_a;
                    default: r = '0;
                endcase
                @(negedge clock);
                @(negedge clock);
                bus.alu_result = r;
                bus.alu_done = 1'b1;
            end
        end
    end

    task automatic wait_drain(int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || ip_pend) && n < budget) begin
            @(negedge clock);
            n++;
        end
        #1;
        if (exp_q.size() != 0 || ip_pend) begin
            compared++;
            mismatched++;
            $display("FAIL drain_timeout: got %0d events pending expected 0", exp_q.size());
            exp_q.delete();
            ip_pend = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            prog[i] = '0;
            dmem[i] = '0;
        end
        dmem[8'h10] = 8'h07;
        dmem[8'h11] = 8'h22;
        prog[8'h00] = enc(1, 0, 5, 0, 3);
        prog[8'h01] = enc(2, 1, 8'h10, 0, 7);
        prog[8'h02] = enc(4, 0, 8'h55, 1, 8'h20);
        prog[8'h03] = enc(5, 0, 8'h40, 0, 0);
        prog[8'h40] = enc(2, 0, 3, 0, 9);
        prog[8'h41] = enc(5, 0, 8'h80, 0, 0);
        prog[8'h42] = enc(6, 0, 8'h80, 0, 0);
        prog[8'h80] = enc(3, 0, 8'h0F, 0, 0);
        prog[8'h81] = enc(1, 0, 1, 1, 8'h11);
        prog[8'h82] = enc(8'h3F, 0, 0, 0, 0);
        prog[8'h83] = enc(7, 0, 8'hFF, 0, 0);
        prog[8'h84] = enc(2, 0, 9, 0, 3);
        prog[8'h85] = enc(7, 0, 8'hFF, 0, 0);
        prog[8'hFF] = enc(0, 0, 0, 0, 0);

        repeat (3) @(negedge clock);
        #1;
        check("reset_cmd_req", bus.cmd_req, 0);
        check("reset_acc", acc, 0);
        check("reset_ip", ip, 0);
        check("reset_retire", retire, 0);

        push(EV_ALU, 1, 5, 3);       e_ret(8'h08, 0, 0, 8'h01);
        push(EV_RD, 8'h10, 0, 0);
        push(EV_ALU, 2, 7, 7);       e_ret(8'h00, 1, 0, 8'h02);
        push(EV_WR, 8'h20, 8'h55, 0); e_ret(8'h00, 1, 0, 8'h03);
        e_ret(8'h00, 1, 0, 8'h40);
        push(EV_ALU, 2, 3, 9);       e_ret(8'hFA, 0, 1, 8'h41);
        e_ret(8'hFA, 0, 1, 8'h42);
        e_ret(8'hFA, 0, 1, 8'h80);
        push(EV_ALU, 3, 8'h0F, 0);   e_ret(8'hF0, 0, 1, 8'h81);
        push(EV_RD, 8'h11, 0, 0);
        push(EV_ALU, 1, 1, 8'h22);   e_ret(8'h23, 0, 1, 8'h82);
        push(EV_ILL, 0, 0, 0);       e_ret(8'h23, 0, 1, 8'h83);
        e_ret(8'h23, 0, 1, 8'h84);
        push(EV_ALU, 2, 9, 3);       e_ret(8'h06, 0, 0, 8'h85);
        e_ret(8'h06, 0, 0, 8'hFF);
        e_ret(8'h06, 0, 0, 8'h00);
        serve_limit = 14;

        @(negedge clock);
        reset = 1'b0;
        #1;
        check("fetch_req", bus.cmd_req, 1);
        check("fetch_addr", bus.cmd_addr, 0);
        wait_drain(2000);

        // Abort an add while it is waiting on the ALU.
        push(EV_ALU, 1, 5, 3);
        alu_stall = 1'b1;
        serve_limit = 15;
        wait_drain(200);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1;
        check("abort_acc", acc, 0);
        check("abort_ip", ip, 0);
        check("abort_flags", {flag_z, flag_lt}, 0);
        check("abort_cmd_req", bus.cmd_req, 0);
        check("abort_alu_start", bus.alu_start, 0);
        check("abort_alu_op", bus.alu_op, 0);
        check("abort_wr_en", bus.mem_wr_en, 0);
        check("abort_rd_req", bus.mem_rd_req, 0);
        check("abort_retire", retire, 0);
        @(negedge clock);
        reset = 1'b0;
        alu_stall = 1'b0;
        @(negedge clock);
        #1;
        check("restart_req", bus.cmd_req, 1);
        check("restart_addr", bus.cmd_addr, 0);
        repeat (10) @(negedge clock);
        #1;
        check("leftover_events", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
